// File: rtl/scan_rw_ctrl.sv
// Scan-side read/write controller: deserialises {rw, addr, wdata}, issues one mux transaction, loads read data back.
// Optional WAIT-state timeout is compiled in with `define SCAN_RW_TIMEOUT_EN.
module scan_rw_ctrl #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              scan_in,
  input  logic              scan_en,
  input  logic              scan_update,
  output logic              scan_out,
  output logic              busy,
  output logic              err,
  output logic              scan_ren,
  output logic              scan_wen,
  output logic [ADDR_W-1:0] scan_addr,
  output logic [DATA_W-1:0] scan_wdata,
  input  logic [DATA_W-1:0] scan_rdata,
  input  logic              scan_ready
);

  localparam int SR_W = 1 + ADDR_W + DATA_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [SR_W-1:0]     sr_q, sr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                ren_q, ren_d;
  logic                wen_q, wen_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;
  logic                timeout_s;

`ifdef SCAN_RW_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counts strobe cycles; held at zero outside REQ/WAIT so every transaction starts fresh.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == REQ || state_q == WAIT) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = {CNT_W{1'b0}};
    end
  end

  // Timeout counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout_s = (state_q == REQ || state_q == WAIT) && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`else
  assign timeout_s = 1'b0;
`endif

  // Next-state, shift register and registered-output logic.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ren_d   = ren_q;
    wen_d   = wen_q;
    busy_d  = busy_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        // Update beats shift: the command is taken from the pre-shift register.
        if (scan_update) begin
          state_d = REQ;
          addr_d  = sr_q[SR_W-2:DATA_W];
          wdata_d = sr_q[DATA_W-1:0];
          wen_d   = sr_q[SR_W-1];
          ren_d   = ~sr_q[SR_W-1];
          busy_d  = 1'b1;
          err_d   = 1'b0;
        end else if (scan_en) begin
          sr_d = {sr_q[SR_W-2:0], scan_in};
        end else begin
          sr_d = sr_q;
        end
      end
      REQ, WAIT: begin
        // sr is frozen while busy, so its MSB still holds the command's rw bit.
        if (scan_ready) begin
          state_d = DONE;
          ren_d   = 1'b0;
          wen_d   = 1'b0;
          if (!sr_q[SR_W-1]) begin
            sr_d[DATA_W-1:0] = scan_rdata;
          end else begin
            sr_d = sr_q;
          end
        end else if (timeout_s) begin
          state_d = DONE;
          ren_d   = 1'b0;
          wen_d   = 1'b0;
          err_d   = 1'b1;
          if (!sr_q[SR_W-1]) begin
            sr_d[DATA_W-1:0] = {DATA_W{1'b1}};
          end else begin
            sr_d = sr_q;
          end
        end else begin
          state_d = WAIT;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        ren_d   = 1'b0;
        wen_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sr_q    <= {SR_W{1'b0}};
      addr_q  <= {ADDR_W{1'b0}};
      wdata_q <= {DATA_W{1'b0}};
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ren_q   <= ren_d;
      wen_q   <= wen_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign scan_out   = sr_q[SR_W-1];
  assign busy       = busy_q;
  assign err        = err_q;
  assign scan_ren   = ren_q;
  assign scan_wen   = wen_q;
  assign scan_addr  = addr_q;
  assign scan_wdata = wdata_q;

endmodule
